// File: rtl/network_mul_share_arb.sv
// network_mul_share_arb: round-robin arbiter that time-shares one signed
// 16x11 -> 27-bit multiplier among N_REQ requesters. Operands are captured
// in S1, the exact product is formed into S2, and results leave on a single
// tagged result channel. Backpressure on that channel stalls the whole pipe.
module network_mul_share_arb #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [16*N_REQ-1:0]     req_a,
    input  logic [11*N_REQ-1:0]     req_b,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [26:0]      res_data,
    output logic [ID_W-1:0]         res_id,
    output logic [31:0]             res_count
);

    localparam int DATA_W = 16;
    localparam int COEF_W = 11;
    localparam int PROD_W = DATA_W + COEF_W;

    // Full-precision signed product; the result width holds every case exactly.
    function automatic logic signed [PROD_W-1:0] mul_full(
        input logic signed [DATA_W-1:0] a,
        input logic signed [COEF_W-1:0] b
    );
        logic signed [PROD_W-1:0] ax;
        logic signed [PROD_W-1:0] bx;
        ax = {{COEF_W{a[DATA_W-1]}}, a};
        bx = {{DATA_W{b[COEF_W-1]}}, b};
        return ax * bx;
    endfunction

    logic signed [DATA_W-1:0] a_arr [N_REQ];
    logic signed [COEF_W-1:0] b_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[DATA_W*g +: DATA_W];
        assign b_arr[g] = req_b[COEF_W*g +: COEF_W];
    end

    logic [ID_W-1:0]          ptr;
    logic [N_REQ-1:0]         grant;
    logic [ID_W-1:0]          gnt_id;
    logic                     gnt_any;
    logic                     hs;
    logic                     adv1;
    logic                     adv2;

    logic signed [DATA_W-1:0] a_p1;
    logic signed [COEF_W-1:0] b_p1;
    logic [ID_W-1:0]          id_p1;
    logic                     vld_p1;

    assign adv2 = !res_valid || res_ready;
    assign adv1 = !vld_p1 || adv2;

    // Round-robin scan starting at ptr; first valid requester wins.
    always_comb begin
        logic [ID_W:0] sum;
        logic [ID_W-1:0] idx;
        grant   = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(N_REQ)) begin
                sum = sum - (ID_W+1)'(N_REQ);
            end
            idx = sum[ID_W-1:0];
            if (!gnt_any && req_valid[idx]) begin
                gnt_any     = 1'b1;
                gnt_id      = idx;
                grant[idx]  = 1'b1;
            end
        end
    end

    // Accept only when S1 can move and never while reset is held.
    always_comb begin
        req_ready = '0;
        hs        = 1'b0;
        if (ap_rst_n && adv1) begin
            req_ready = grant;
            hs        = gnt_any;
        end
    end

    // Pointer moves past the served requester; unchanged with no handshake.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ptr <= '0;
        end else if (hs) begin
            ptr <= (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
        end
    end

    // S1: capture granted operands and tag.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            a_p1   <= '0;
            b_p1   <= '0;
            id_p1  <= '0;
            vld_p1 <= 1'b0;
        end else if (adv1) begin
            a_p1   <= a_arr[gnt_id];
            b_p1   <= b_arr[gnt_id];
            id_p1  <= gnt_id;
            vld_p1 <= hs;
        end
    end

    // S2: exact product and tag, held while the consumer stalls.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            res_data  <= '0;
            res_id    <= '0;
            res_valid <= 1'b0;
        end else if (adv2) begin
            res_data  <= mul_full(a_p1, b_p1);
            res_id    <= id_p1;
            res_valid <= vld_p1;
        end
    end

    // Completed result handshakes, wrapping naturally at 2^32.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            res_count <= '0;
        end else if (res_valid && res_ready) begin
            res_count <= res_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_network_mul_share_arb.sv
// Directed bench for network_mul_share_arb with a result scoreboard.
module tb_network_mul_share_arb;

    logic               ap_clk;
    logic               ap_rst_n;
    logic [3:0]         req_valid;
    logic [3:0]         req_ready;
    logic [63:0]        req_a;
    logic [43:0]        req_b;
    logic               res_valid;
    logic               res_ready;
    logic signed [26:0] res_data;
    logic [1:0]         res_id;
    logic [31:0]        res_count;

    logic signed [15:0] ta  [4];
    logic signed [10:0] tbv [4];

    for (genvar g = 0; g < 4; g++) begin : g_pack
        assign req_a[16*g +: 16] = ta[g];
        assign req_b[11*g +: 11] = tbv[g];
    end

    network_mul_share_arb #(.N_REQ(4), .ID_W(2)) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_count (res_count)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int     checks = 0;
    int     errors = 0;
    int     hs_total = 0;
    int     res_total = 0;
    longint exp_q [$];
    int     eid_q [$];
    int     grants [$];

    task automatic chk(input string tag, input longint obs, input longint exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Settle after the falling-edge drive, then log handshakes and score results.
    task automatic settle();
        #1;
        for (int i = 0; i < 4; i++) begin
            if (req_valid[2'(i)] && req_ready[2'(i)]) begin
                exp_q.push_back(longint'(ta[2'(i)]) * longint'(tbv[2'(i)]));
                eid_q.push_back(i);
                grants.push_back(i);
                hs_total++;
            end
        end
        chk("ready_onehot", longint'($countones(req_ready) <= 1), 1);
        if (res_valid && res_ready) begin
            res_total++;
            chk("res_expected", longint'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                chk("res_data", res_data, exp_q.pop_front());
                chk("res_id", res_id, eid_q.pop_front());
            end
        end
    endtask

    task automatic adv();
        @(negedge ap_clk);
    endtask

    task automatic step();
        settle();
        adv();
    endtask

    initial begin
        int     n;
        int     acc0;
        longint held;
        int     ea [3];
        int     eb [3];

        ap_rst_n  = 1'b0;
        res_ready = 1'b0;
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            ta[i]  = '0;
            tbv[i] = '0;
        end

        // Reset state, with requests present during reset
        @(negedge ap_clk);
        req_valid = 4'b1111;
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_data", res_data, 0);
        chk("rst_id", res_id, 0);
        chk("rst_count", res_count, 0);
        @(negedge ap_clk);
        req_valid = '0;
        ap_rst_n  = 1'b1;
        adv();

        // Single op, latency 2
        ta[0] = 16'sd32767;
        tbv[0] = 11'sd1023;
        req_valid = 4'b0001;
        res_ready = 1'b1;
        settle();
        chk("t1_ready", req_ready, 1);
        adv();
        req_valid = '0;
        settle();
        chk("t1_early", res_valid, 0);
        adv();
        settle();
        chk("t1_valid", res_valid, 1);
        chk("t1_data", res_data, 33520641);
        chk("t1_id", res_id, 0);
        adv();
        settle();
        chk("t1_count", res_count, 1);
        adv();

        // Extreme signs back to back from a single requester
        ea[0] = -32768; eb[0] = -1024;
        ea[1] = -32768; eb[1] = 1023;
        ea[2] = 5;      eb[2] = -1;
        req_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            ta[0]  = 16'(ea[k]);
            tbv[0] = 11'(eb[k]);
            settle();
            chk("t2_ready", req_ready, 1);
            if (k == 2) chk("t2_maxpos", res_data, 33554432);
            adv();
        end
        req_valid = '0;
        settle();
        chk("t2_maxneg", res_data, -33521664);
        adv();
        settle();
        chk("t2_small", res_data, -5);
        adv();
        settle();
        chk("t2_idle", res_valid, 0);
        chk("t2_count", res_count, 4);
        adv();

        // Requester 3 once, leaving the pointer at 0
        ta[3] = -16'sd1;
        tbv[3] = -11'sd1;
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        step();
        step();

        // Fairness: all four valid continuously
        for (int i = 0; i < 4; i++) begin
            ta[i]  = 16'(-20000 + 7000 * i);
            tbv[i] = 11'(300 - 211 * i);
        end
        grants.delete();
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            settle();
            if (k >= 2) chk("t3_stream", res_valid, 1);
            adv();
        end
        req_valid = '0;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("t3_tail", res_valid, 1);
            adv();
        end
        settle();
        chk("t3_idle", res_valid, 0);
        adv();
        chk("t3_ngrant", grants.size(), 8);
        for (int k = 0; k < 8 && k < grants.size(); k++) begin
            chk("t3_order", grants[k], k % 4);
        end

        // Backpressure on a stream from requester 2
        res_ready = 1'b0;
        n = 0;
        held = 0;
        ta[2] = -16'sd3000;
        tbv[2] = 11'sd17;
        req_valid = 4'b0100;
        acc0 = hs_total;
        for (int k = 0; k < 5; k++) begin
            settle();
            if (k >= 2) begin
                chk("t4_ready_zero", req_ready, 0);
                chk("t4_hold_valid", res_valid, 1);
                if (k == 2) begin
                    held = res_data;
                    chk("t4_first", res_data, -51000);
                end else begin
                    chk("t4_hold_data", res_data, held);
                end
            end
            if (req_ready[2]) n++;
            adv();
            ta[2]  = 16'(-3000 + 1111 * n);
            tbv[2] = 11'(17 + n);
        end
        chk("t4_accepted", hs_total - acc0, 2);
        res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            if (k == 0) chk("t4_release_ready", req_ready, 4'b0100);
            if (req_ready[2]) n++;
            adv();
            ta[2]  = 16'(-3000 + 1111 * n);
            tbv[2] = 11'(17 + n);
        end
        req_valid = '0;
        for (int k = 0; k < 3; k++) step();
        chk("t4_drained", exp_q.size(), 0);
        chk("t4_balance", hs_total, res_total);

        // Sparse: pointer to 2 via requester 1, then {1,3}, then add 0
        ta[1] = 16'sd1234;
        tbv[1] = -11'sd77;
        req_valid = 4'b0010;
        step();
        ta[3] = -16'sd4321;
        tbv[3] = 11'sd99;
        ta[0] = 16'sd222;
        tbv[0] = 11'sd333;
        grants.delete();
        req_valid = 4'b1010;
        for (int k = 0; k < 3; k++) step();
        req_valid = 4'b1011;
        for (int k = 0; k < 3; k++) step();
        req_valid = '0;
        for (int k = 0; k < 3; k++) step();
        chk("t5_ngrant", grants.size(), 6);
        if (grants.size() == 6) begin
            chk("t5_g0", grants[0], 3);
            chk("t5_g1", grants[1], 1);
            chk("t5_g2", grants[2], 3);
            chk("t5_g3", grants[3], 0);
            chk("t5_g4", grants[4], 1);
            chk("t5_g5", grants[5], 3);
        end
        chk("t5_drained", exp_q.size(), 0);

        // Reset with both stages full
        res_ready = 1'b0;
        req_valid = 4'b1111;
        step();
        step();
        settle();
        chk("t6_pre_valid", res_valid, 1);
        chk("t6_pre_stall", req_ready, 0);
        ap_rst_n = 1'b0;
        #1;
        chk("t6_valid", res_valid, 0);
        chk("t6_data", res_data, 0);
        chk("t6_id", res_id, 0);
        chk("t6_count", res_count, 0);
        chk("t6_ready", req_ready, 0);
        exp_q.delete();
        eid_q.delete();
        adv();
        req_valid = 4'b1100;
        res_ready = 1'b1;
        ap_rst_n  = 1'b1;
        grants.delete();
        settle();
        chk("t6_first_grant", req_ready, 4'b0100);
        adv();
        req_valid = '0;
        for (int k = 0; k < 3; k++) step();
        chk("t6_ngrant", grants.size(), 1);
        chk("t6_drained", exp_q.size(), 0);
        chk("t6_count_after", res_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
